// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared types and constants for the accumulator CPU sequencer
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    MEM    = 3'd3,
    EXEC   = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } seq_state_t;

  localparam int MEM_TIMEOUT_DEF = 15;
  localparam int CNT_W_DEF       = 16;
  localparam int WAIT_W          = 8;

  typedef struct packed {
    logic mem_rd;
    logic mem_wr;
    logic reg_ce;
    logic aku_en;
    logic aku_mul_en;
    logic halt;
  } dec_flags_t;

endpackage

// File: rtl/seq_wait_timer.sv
// rtl/seq_wait_timer.sv - loadable down-counter with expiry flag for memory wait bounding
module seq_wait_timer
  import cpu_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic              load,
  input  logic [WAIT_W-1:0] load_val,
  input  logic              en,
  output logic              expired
);

  logic [WAIT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle fetch/decode/mem/exec/writeback control FSM
module cpu_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             run,
  input  logic             step,
  input  logic             stop,
  input  logic             dec_mem_rd,
  input  logic             dec_mem_wr,
  input  logic             dec_reg_ce,
  input  logic             dec_aku_en,
  input  logic             dec_aku_mul_en,
  input  logic             dec_halt,
  input  logic             mem_ack,
  output logic             ir_load,
  output logic             pc_en,
  output logic             reg_ce,
  output logic             aku_en,
  output logic             aku_mul_en,
  output logic             mem_req,
  output logic             mem_wr,
  output logic             busy,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] instr_cnt
);

  // Timer counts remaining no-ack cycles; the last MEM cycle sees zero.
  localparam logic [WAIT_W-1:0] TMO_LOAD = WAIT_W'(MEM_TIMEOUT - 1);

  seq_state_t state, state_nxt;
  dec_flags_t dec_in;
  logic lat_rd, lat_wr, lat_reg_ce, lat_aku, lat_mul;
  logic single, stop_pend;
  logic tmo_expired, timeout;

  assign dec_in = '{mem_rd: dec_mem_rd, mem_wr: dec_mem_wr, reg_ce: dec_reg_ce,
                    aku_en: dec_aku_en, aku_mul_en: dec_aku_mul_en, halt: dec_halt};

  seq_wait_timer u_wait_timer (
    .clk      (clk),
    .clr      (clr),
    .load     (state == DECODE),
    .load_val (TMO_LOAD),
    .en       ((state == MEM) && !mem_ack),
    .expired  (tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (!clr) begin
      state      <= IDLE;
      lat_rd     <= 1'b0;
      lat_wr     <= 1'b0;
      lat_reg_ce <= 1'b0;
      lat_aku    <= 1'b0;
      lat_mul    <= 1'b0;
      single     <= 1'b0;
      stop_pend  <= 1'b0;
      mem_err    <= 1'b0;
      instr_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && (run || step)) single <= !run;
      if (state == DECODE) begin
        // A combined read+write decode is executed as a store.
        lat_rd     <= dec_in.mem_rd && !dec_in.mem_wr;
        lat_wr     <= dec_in.mem_wr;
        lat_reg_ce <= dec_in.reg_ce;
        lat_aku    <= dec_in.aku_en;
        lat_mul    <= dec_in.aku_mul_en;
      end
      if (state == WB) stop_pend <= 1'b0;
      else if (stop && busy) stop_pend <= 1'b1;
      if (timeout) mem_err <= 1'b1;
      if (state == WB) instr_cnt <= instr_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    timeout    = 1'b0;
    ir_load    = 1'b0;
    pc_en      = 1'b0;
    reg_ce     = 1'b0;
    aku_en     = 1'b0;
    aku_mul_en = 1'b0;
    mem_req    = 1'b0;
    mem_wr     = 1'b0;
    busy       = (state != IDLE) && (state != HALT);
    halted     = (state == HALT);
    case (state)
      IDLE:   if (run || step) state_nxt = FETCH;
      FETCH: begin
        ir_load   = 1'b1;
        state_nxt = DECODE;
      end
      DECODE: begin
        if (dec_in.halt) state_nxt = HALT;
        else if (dec_in.mem_rd || dec_in.mem_wr) state_nxt = MEM;
        else state_nxt = EXEC;
      end
      MEM: begin
        mem_req = 1'b1;
        mem_wr  = lat_wr;
        if (mem_ack && lat_wr) state_nxt = WB;
        else if (mem_ack && lat_rd) state_nxt = EXEC;
        else if (!mem_ack && tmo_expired) begin
          timeout   = 1'b1;
          state_nxt = HALT;
        end
      end
      EXEC: begin
        aku_en     = lat_aku;
        aku_mul_en = lat_mul;
        state_nxt  = WB;
      end
      WB: begin
        reg_ce    = lat_reg_ce;
        pc_en     = 1'b1;
        state_nxt = (single || stop_pend || stop) ? IDLE : FETCH;
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - directed self-checking bench for cpu_sequencer
module tb_cpu_sequencer;

  logic clk = 1'b0;
  logic clr, run, step, stop;
  logic dec_mem_rd, dec_mem_wr, dec_reg_ce, dec_aku_en, dec_aku_mul_en, dec_halt;
  logic mem_ack;
  logic ir_load, pc_en, reg_ce, aku_en, aku_mul_en, mem_req, mem_wr, busy, halted, mem_err;
  logic [15:0] instr_cnt;
  logic [9:0] ctl;

  int n_tests = 0;
  int n_fail  = 0;

  // ctl = {ir_load,pc_en,reg_ce,aku_en,aku_mul_en,mem_req,mem_wr,busy,halted,mem_err}
  localparam logic [9:0] C_IDLE  = 10'b0000000000;
  localparam logic [9:0] C_FETCH = 10'b1000000100;
  localparam logic [9:0] C_DEC   = 10'b0000000100;
  localparam logic [9:0] C_EXA   = 10'b0001000100;
  localparam logic [9:0] C_EX0   = 10'b0000000100;
  localparam logic [9:0] C_WBR   = 10'b0110000100;
  localparam logic [9:0] C_WB    = 10'b0100000100;
  localparam logic [9:0] C_MRD   = 10'b0000010100;
  localparam logic [9:0] C_MWR   = 10'b0000011100;
  localparam logic [9:0] C_HALT  = 10'b0000000010;
  localparam logic [9:0] C_HERR  = 10'b0000000011;

  assign ctl = {ir_load, pc_en, reg_ce, aku_en, aku_mul_en, mem_req, mem_wr, busy, halted, mem_err};

  always #5 clk = ~clk;

  cpu_sequencer #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
    .clk(clk), .clr(clr), .run(run), .step(step), .stop(stop),
    .dec_mem_rd(dec_mem_rd), .dec_mem_wr(dec_mem_wr), .dec_reg_ce(dec_reg_ce),
    .dec_aku_en(dec_aku_en), .dec_aku_mul_en(dec_aku_mul_en), .dec_halt(dec_halt),
    .mem_ack(mem_ack), .ir_load(ir_load), .pc_en(pc_en), .reg_ce(reg_ce),
    .aku_en(aku_en), .aku_mul_en(aku_mul_en), .mem_req(mem_req), .mem_wr(mem_wr),
    .busy(busy), .halted(halted), .mem_err(mem_err), .instr_cnt(instr_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic [5:0] f);
    {dec_mem_rd, dec_mem_wr, dec_reg_ce, dec_aku_en, dec_aku_mul_en, dec_halt} = f;
  endtask

  task automatic do_reset();
    clr = 1'b0;
    tick();
    tick();
    clr = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b0; run = 1'b0; step = 1'b0; stop = 1'b0; mem_ack = 1'b0;
    set_dec(6'b000000);

    // reset and idle
    do_reset();
    for (int i = 0; i < 10; i++) check("idle_ctl_cnt", {6'd0, ctl, instr_cnt}, {6'd0, C_IDLE, 16'd0});

    // ALU run of three instructions, stop during the third EXEC
    set_dec(6'b001100);
    run = 1'b1; tick(); run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("alu_fetch", ctl, C_FETCH);
      check("alu_cnt", instr_cnt, i);
      tick(); check("alu_decode", ctl, C_DEC);
      tick(); check("alu_exec", ctl, C_EXA);
      if (i == 2) stop = 1'b1;
      tick(); stop = 1'b0;
      check("alu_wb", ctl, C_WBR);
      tick();
    end
    check("stop_idle", ctl, C_IDLE);
    check("stop_cnt", instr_cnt, 3);
    tick(); check("stop_stays_idle", ctl, C_IDLE);

    // run and step together: run wins, continuous; stop in EXEC of second instruction
    set_dec(6'b000010);
    run = 1'b1; step = 1'b1; tick(); run = 1'b0; step = 1'b0;
    check("prio_fetch", ctl, C_FETCH);
    tick(); tick(); check("prio_exec_mul", ctl, 10'b0000100100);
    tick(); check("prio_wb", ctl, C_WB);
    tick(); check("prio_continuous", ctl, C_FETCH);
    tick(); tick(); stop = 1'b1; tick(); stop = 1'b0;
    check("prio_wb2", ctl, C_WB);
    tick(); check("prio_idle", ctl, C_IDLE);
    check("prio_cnt", instr_cnt, 5);

    // load with two wait states via step
    set_dec(6'b100000);
    step = 1'b1; tick(); step = 1'b0;
    check("ld_fetch", ctl, C_FETCH);
    tick(); check("ld_decode", ctl, C_DEC);
    tick(); check("ld_mem1", ctl, C_MRD);
    tick(); check("ld_mem2", ctl, C_MRD);
    tick(); check("ld_mem3", ctl, C_MRD);
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    check("ld_exec", ctl, C_EX0);
    tick(); check("ld_wb", ctl, C_WB);
    tick(); check("ld_idle", ctl, C_IDLE);
    check("ld_cnt", instr_cnt, 6);

    // store with rd+wr set, zero wait states
    set_dec(6'b110000);
    step = 1'b1; tick(); step = 1'b0;
    tick(); tick(); check("st_mem", ctl, C_MWR);
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    check("st_wb", ctl, C_WB);
    tick(); check("st_idle", ctl, C_IDLE);
    check("st_cnt", instr_cnt, 7);

    // halt beats mem_rd
    set_dec(6'b100001);
    step = 1'b1; tick(); step = 1'b0;
    tick(); tick(); check("halt_state", ctl, C_HALT);
    step = 1'b1; run = 1'b1; tick(); step = 1'b0; run = 1'b0;
    tick(); check("halt_sticky", ctl, C_HALT);
    check("halt_cnt", instr_cnt, 7);

    // recover, one ALU step, then reset in the middle of MEM
    do_reset();
    check("rst_after_halt", {6'd0, ctl, instr_cnt}, {6'd0, C_IDLE, 16'd0});
    set_dec(6'b000100);
    step = 1'b1; tick(); step = 1'b0;
    tick(); tick(); tick(); tick();
    check("step_alu_cnt", instr_cnt, 1);
    set_dec(6'b100000);
    step = 1'b1; tick(); step = 1'b0;
    tick(); tick(); check("midmem_req", ctl, C_MRD);
    tick(); check("midmem_req2", ctl, C_MRD);
    clr = 1'b0; tick(); clr = 1'b1;
    check("midmem_cleared", {6'd0, ctl, instr_cnt}, {6'd0, C_IDLE, 16'd0});

    // store timeout after 4 un-acked MEM cycles
    set_dec(6'b010000);
    step = 1'b1; tick(); step = 1'b0;
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      check("tmo_mem", ctl, C_MWR);
      tick();
    end
    check("tmo_halt_err", ctl, C_HERR);
    run = 1'b1; tick(); run = 1'b0;
    tick(); tick();
    check("tmo_run_ignored", ctl, C_HERR);
    check("tmo_cnt", instr_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
